// File: rtl/aes_round_stage.sv
// AES encryption round back-end: ShiftRows, MixColumns (bypassed on the final round) and
// AddRoundKey into a valid/ready output register. Define AES_ROUND_SKID_EN for a registered in_ready.
module aes_round_stage #(
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_state,
    input  logic [127:0]       in_key,
    input  logic               in_final,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_state,
    output logic               out_final,
    output logic [TAG_W-1:0]   out_tag
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Bytes are column-major: byte k sits at row k%4, column k/4, MSB first.
    function automatic logic [127:0] round_fn(input logic [127:0] st,
                                              input logic [127:0] key,
                                              input logic         fin);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   mc [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        res = '0;
        for (int k = 0; k < 16; k++) begin
            sb[k] = st[127-8*k -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (int k = 0; k < 16; k++) begin
            res[127-8*k -: 8] = (fin ? sr[k] : mc[k]) ^ key[127-8*k -: 8];
        end
        return res;
    endfunction

    logic [127:0]     round_state;
    logic             accept;
    logic             out_valid_q, out_valid_d;
    logic [127:0]     out_state_q, out_state_d;
    logic             out_final_q, out_final_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;

    always_comb begin
        round_state = round_fn(in_state, in_key, in_final);
    end

`ifdef AES_ROUND_SKID_EN
    logic             out_xfer;
    logic             skid_valid_q, skid_valid_d;
    logic [127:0]     skid_state_q, skid_state_d;
    logic             skid_final_q, skid_final_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

    // A full skid entry is always older than any new beat, so it drains first.
    always_comb begin
        in_ready     = !skid_valid_q;
        accept       = in_valid & in_ready;
        out_xfer     = out_valid_q & out_ready;
        out_valid_d  = out_valid_q;
        out_state_d  = out_state_q;
        out_final_d  = out_final_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_state_d = skid_state_q;
        skid_final_d = skid_final_q;
        skid_tag_d   = skid_tag_q;
        if (skid_valid_q) begin
            if (out_xfer) begin
                out_valid_d  = 1'b1;
                out_state_d  = skid_state_q;
                out_final_d  = skid_final_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || out_xfer) begin
            out_valid_d = accept;
            if (accept) begin
                out_state_d = round_state;
                out_final_d = in_final;
                out_tag_d   = in_tag;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_state_d = round_state;
            skid_final_d = in_final;
            skid_tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_state_q <= '0;
            skid_final_q <= 1'b0;
            skid_tag_q   <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_state_q <= skid_state_d;
            skid_final_q <= skid_final_d;
            skid_tag_q   <= skid_tag_d;
        end
    end
`else
    always_comb begin
        in_ready    = !out_valid_q | out_ready;
        accept      = in_valid & in_ready;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_final_d = out_final_q;
        out_tag_d   = out_tag_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_state_d = round_state;
            out_final_d = in_final;
            out_tag_d   = in_tag;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_final_q <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_final_q <= out_final_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_final = out_final_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_aes_round_stage.sv
// Directed-vector bench for aes_round_stage: streaming table, backpressure and reset-mid-stall sequences.
module tb_aes_round_stage;

    localparam int TAG_W  = 4;
    localparam int NUM_VEC = 8;

    typedef struct {
        logic [127:0]     state;
        logic [127:0]     key;
        logic             fin;
        logic [TAG_W-1:0] tag;
        logic [127:0]     expected;
    } vec_t;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       in_state;
    logic [127:0]       in_key;
    logic               in_final;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       out_state;
    logic               out_final;
    logic [TAG_W-1:0]   out_tag;

    int checks;
    int failures;
    vec_t vecs [NUM_VEC];

    aes_round_stage #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_final  (in_final),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_final (out_final),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input vec_t v);
        in_valid = 1'b1;
        in_state = v.state;
        in_key   = v.key;
        in_final = v.fin;
        in_tag   = v.tag;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    initial begin
        logic [127:0] rx [4];
        int           rx_count;
        int           accepts;
        logic         acc;
        logic         exp_ready;

        checks   = 0;
        failures = 0;

        // FIPS-197 App. B round 1 and last round
        vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
                    1'b0, 4'h1, 128'ha49c7ff2689f352b6b5bea43026a5049};
        vecs[1] = '{128'he9098972cb31075f3d327d94af2e2cb5, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                    1'b1, 4'ha, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h0, 128'h0, 1'b0, 4'h2, 128'h0};
        vecs[3] = '{128'h0, {128{1'b1}}, 1'b0, 4'h3, {128{1'b1}}};
        // identical columns make ShiftRows a no-op, isolating MixColumns
        vecs[4] = '{128'hdb135345db135345db135345db135345, 128'h0,
                    1'b0, 4'h4, 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc};
        vecs[5] = '{128'hf20a225cf20a225cf20a225cf20a225c, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f,
                    1'b0, 4'h6, 128'h90d3579290d3579290d3579290d35792};
        vecs[6] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0,
                    1'b1, 4'h5, 128'h00050a0f04090e03080d02070c01060b};
        vecs[7] = '{128'hdb135345db135345db135345db135345, 128'h0,
                    1'b1, 4'hf, 128'hdb135345db135345db135345db135345};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        in_key    = '0;
        in_final  = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 128'(out_valid), 128'h0);
        checkOutput("reset out_state", out_state, 128'h0);
        checkOutput("reset out_final", 128'(out_final), 128'h0);
        checkOutput("reset out_tag", 128'(out_tag), 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset in_ready", 128'(in_ready), 128'h1);

        // Back-to-back stream with out_ready held high
        @(posedge clk);
        #1;
        applyStimulus(vecs[0]);
        for (int i = 0; i < NUM_VEC; i++) begin
            @(posedge clk);
            #1;
            if (i + 1 < NUM_VEC) applyStimulus(vecs[i+1]);
            else in_valid = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'h1);
            checkOutput($sformatf("vec%0d out_state", i), out_state, vecs[i].expected);
            checkOutput($sformatf("vec%0d out_final", i), 128'(out_final), 128'(vecs[i].fin));
            checkOutput($sformatf("vec%0d out_tag", i), 128'(out_tag), 128'(vecs[i].tag));
            checkOutput($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'h1);
        end

        // Drain with no new beat: valid drops, payload holds
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("drain out_valid", 128'(out_valid), 128'h0);
        checkOutput("drain out_state hold", out_state, vecs[NUM_VEC-1].expected);
        checkOutput("drain out_tag hold", 128'(out_tag), 128'(vecs[NUM_VEC-1].tag));

        // Backpressure: A held in the output, B offered during a 3-cycle stall
        @(posedge clk);
        #1;
        applyStimulus(vecs[0]);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(vecs[1]);
        accepts = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
`ifdef AES_ROUND_SKID_EN
            exp_ready = (j == 0);
`else
            exp_ready = 1'b0;
`endif
            checkOutput($sformatf("stall%0d out_valid", j), 128'(out_valid), 128'h1);
            checkOutput($sformatf("stall%0d out_state", j), out_state, vecs[0].expected);
            checkOutput($sformatf("stall%0d out_tag", j), 128'(out_tag), 128'(vecs[0].tag));
            checkOutput($sformatf("stall%0d in_ready", j), 128'(in_ready), 128'(exp_ready));
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                accepts++;
                in_valid = 1'b0;
            end
        end

        out_ready = 1'b1;
        rx_count  = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            acc = in_valid & in_ready;
            if (out_valid && out_ready && rx_count < 4) begin
                rx[rx_count] = out_state;
                rx_count++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                accepts++;
                in_valid = 1'b0;
            end
        end
        checkOutput("bp beat B accepted once", 128'(accepts), 128'd1);
        checkOutput("bp result count", 128'(rx_count), 128'd2);
        if (rx_count >= 2) begin
            checkOutput("bp first result", rx[0], vecs[0].expected);
            checkOutput("bp second result", rx[1], vecs[1].expected);
        end
        @(negedge clk);
        checkOutput("bp idle out_valid", 128'(out_valid), 128'h0);

        // Reset asserted mid-stall, away from any clock edge
        @(posedge clk);
        #1;
        applyStimulus(vecs[4]);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("pre-reset out_valid", 128'(out_valid), 128'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", 128'(out_valid), 128'h0);
        checkOutput("async reset out_state", out_state, 128'h0);
        checkOutput("async reset out_tag", 128'(out_tag), 128'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post-reset in_ready", 128'(in_ready), 128'h1);
        @(posedge clk);
        #1;
        applyStimulus(vecs[5]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post-reset out_valid", 128'(out_valid), 128'h1);
        checkOutput("post-reset out_state", out_state, vecs[5].expected);
        checkOutput("post-reset out_tag", 128'(out_tag), 128'(vecs[5].tag));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_stage.md
Name: aes_round_stage

Overview:
- Registered AES encryption round back-end that sits directly downstream of subBytes.
- Accepts the 128-bit SubBytes output plus a 128-bit round key, then applies ShiftRows, MixColumns (skipped on the final round) and AddRoundKey.
- Presents the result on a valid/ready output register, one round per transfer.
- Feeds either the next subBytes pass of an iterative cipher or the ciphertext sink.

Parameters:
- TAG_W, 4, width of the sideband tag carried alongside each block (e.g. round number); allowed range 1..16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_state  in  128  SubBytes output; byte k = in_state[127-8k -: 8]; column-major, byte k = row k%4, column k/4
- in_key  in  128  round key, same byte order
- in_final  in  1  1 = final round, MixColumns bypassed
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output register holds a result
- out_ready  in  1  consumer accepts the output
- out_state  out  128  round result
- out_final  out  1  registered copy of in_final
- out_tag  out  TAG_W  registered copy of in_tag

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_state=0, out_final=0, out_tag=0; in_ready=1 once rst_n is high.
- Handshake: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready. Payload must be held stable while valid is high and ready is low.
- in_ready = !out_valid | out_ready (combinational).
- Latency: 1 cycle. A beat accepted at edge N has out_valid=1 after edge N. Back-to-back throughput is 1 beat/cycle while out_ready=1.
- Simultaneous output transfer and input transfer on one edge: the register is overwritten with the new beat and out_valid stays 1.
- Output transfer with no input transfer: out_valid goes to 0. out_state, out_final and out_tag hold their last values.
- Stall (out_valid=1, out_ready=0): all outputs are frozen and in_ready=0.
- ShiftRows: out byte (r,c) = in byte (r,(c+r) mod 4).
- MixColumns per column uses GF(2^8) with polynomial 0x11B:
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0)
  - s'0=2a0^3a1^a2^a3
  - s'1=a0^2a1^3a2^a3
  - s'2=a0^a1^2a2^3a3
  - s'3=3a0^a1^a2^2a3
- AddRoundKey: XOR with in_key after MixColumns, or after ShiftRows when in_final=1.
- All combinational logic sits ahead of the output register. No combinational path from in_* to out_*.
- Reset mid-operation: any held result is discarded and out_valid=0 immediately (asynchronous).

Optional Feature:
- Macro: AES_ROUND_SKID_EN.
- Defined:
  - Adds a one-entry skid register and makes in_ready a pure register output (no path from out_ready).
  - in_ready=1 iff the skid entry is empty.
  - When the output register is full and not draining, an accepted beat is computed and parked in the skid entry. On the next output transfer it moves into the output register.
  - Ordering is preserved and latency is unchanged when not stalled. Capacity is 2 beats. The skid entry clears on reset.
- Undefined: the single-register behaviour above.

Test Plan:
- FIPS-197 App. B round 1: in_state=d42711aee0bf98f1b8b45de51e415230, in_key=a0fafe1788542cb123a339392a6c7605, in_final=0, in_tag=1 -> next cycle out_state=a49c7ff2689f352b6b5bea43026a5049, out_tag=1.
- Final round: in_state=e9098972cb31075f3d327d94af2e2cb5, in_key=d014f9a8c9ee2589e13f0cc8b6630ca6, in_final=1 -> out_state=3925841d02dc09fbdc118597196a0b32, out_final=1.
- Throughput: the two beats above presented back-to-back with out_ready=1 -> results on consecutive cycles, in_ready constantly 1.
- Backpressure: out_ready=0 for 3 cycles with the first beat held -> out_state stable at a49c7ff2…; in_ready=0 (with AES_ROUND_SKID_EN: exactly one extra beat is accepted, then in_ready=0). Release -> results emerge in order with no loss or duplication.
- Reset mid-stall: rst_n=0 while out_valid=1 -> out_valid=0 and out_state=0 asynchronously. After release, in_ready=1 and the next beat is processed normally.
- Zero vector: in_state=0, in_key=0, in_final=0 -> out_state=0. Same with in_key=ff…ff -> out_state=ff…ff.
